elpis_print_buffer: RTL

- Parametrised output buffer between the Elpis core's print path and the Caravel management side.
- The core pushes tagged print words into a FIFO; firmware drains them over Wishbone.
- Logic-analyzer flags report data-available and overflow.
- Generalises the single fixed print word to N channels, configurable depth/width, and a selectable full-policy (backpressure or drop).

---
 rtl/elpis_print_buffer_pkg.sv | 7 +
 rtl/elpis_print_buffer_fifo.sv | 38 +++
 rtl/elpis_print_buffer.sv | 80 ++++++++
 3 files changed

// File: rtl/elpis_print_buffer_pkg.sv
// print_buf_pkg: register map, field indices and full-policy mode for elpis_print_buffer.
package print_buf_pkg;
  localparam logic [1:0] ADDR_DATA = 2'd0, ADDR_STATUS = 2'd1, ADDR_CTRL = 2'd2;
  localparam int ST_EMPTY = 0, ST_FULL = 1, ST_OVF = 2, ST_MODE = 3, ST_CHAN = 4, ST_COUNT = 8;
  localparam int CTRL_MODE = 0, CTRL_CLEAR = 1;
  typedef enum logic {MODE_BLOCK = 1'b0, MODE_DROP = 1'b1} mode_e;
endpackage

// File: rtl/elpis_print_buffer_fifo.sv
// sync_fifo_ff: flop-based FIFO with one extra pointer bit so count = wr_ptr - rd_ptr.
module sync_fifo_ff #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic [WIDTH-1:0] head
);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign count = wr_ptr - rd_ptr;
  assign full  = count[AW];
  assign empty = count == '0;
  assign head  = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + CW'(1);
      if (pop) rd_ptr <= rd_ptr + CW'(1);
    end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/elpis_print_buffer.sv
// elpis_print_buffer: tagged print FIFO drained over Wishbone, with BLOCK/DROP full policy and LA flags.
module elpis_print_buffer
  import print_buf_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = 8,
  parameter int CHANNELS = 2,
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int AW = $clog2(DEPTH)
)(
  input  logic              wb_clk_i,
  input  logic              rst_n,
  input  logic              print_valid,
  input  logic [DATA_W-1:0] print_data,
  input  logic [CH_W-1:0]   print_chan,
  output logic              print_ready,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic [31:0]       wbs_dat_o,
  output logic              wbs_ack_o,
  output logic              la_avail,
  output logic              la_overflow
);
  localparam int CW = AW + 1;
  mode_e mode;
  logic req, wr, rd, pop, push, clear, w1c, drop, full, empty;
  logic [1:0] sel;
  logic [AW:0] count, cnt_n;
  logic [CH_W-1:0] head_ch;
  logic [DATA_W-1:0] head_data;
  logic [31:0] status, rdata;
  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i[31:3]};
  assign sel   = wbs_adr_i[3:2];
  assign req   = wbs_cyc_i && wbs_stb_i && !wbs_ack_o;
  assign wr    = req && wbs_we_i;
  assign rd    = req && !wbs_we_i;
  assign print_ready = mode == MODE_DROP || !full;
  assign pop   = rd && sel == ADDR_DATA && !empty;
  assign clear = wr && sel == ADDR_CTRL && wbs_dat_i[CTRL_CLEAR];
  assign w1c   = wr && sel == ADDR_STATUS && wbs_dat_i[ST_OVF];
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push  = print_valid && print_ready && (!full || pop) && !clear;
  assign drop  = print_valid && print_ready && full && !pop && !clear;
  assign cnt_n = clear ? '0 : count + CW'(push) - CW'(pop);
  sync_fifo_ff #(.WIDTH(DATA_W + CH_W), .DEPTH(DEPTH)) u_fifo (
    .clk(wb_clk_i), .rst_n(rst_n), .push(push), .pop(pop), .flush(clear),
    .din({print_chan, print_data}), .full(full), .empty(empty), .count(count),
    .head({head_ch, head_data})
  );
  always_comb begin
    status = '0;
    status[ST_EMPTY] = empty;
    status[ST_FULL] = full;
    status[ST_OVF] = la_overflow;
    status[ST_MODE] = mode;
    status[ST_CHAN +: 4] = empty ? 4'd0 : 4'(head_ch);
    status[ST_COUNT +: 8] = 8'(count);
    rdata = sel == ADDR_DATA ? (empty ? 32'd0 : 32'(head_data)) :
            sel == ADDR_STATUS ? status :
            sel == ADDR_CTRL ? 32'(mode) : 32'd0;
  end
  always_ff @(posedge wb_clk_i or negedge rst_n)
    if (!rst_n) begin
      mode <= MODE_BLOCK;
      la_overflow <= 1'b0;
      la_avail <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= req;
      if (rd) wbs_dat_o <= rdata;
      if (wr && sel == ADDR_CTRL) mode <= mode_e'(wbs_dat_i[CTRL_MODE]);
      la_overflow <= !clear && ((la_overflow && !w1c) || drop);
      la_avail <= cnt_n != '0;
    end
endmodule
